// File: rtl/uart_tx_arbiter.sv
// Two-requester, packet-locked, round-robin byte arbiter in front of a UART transmitter.
// Define UART_TX_ARB_TIMEOUT_EN to release a grant whose owner stalls for TIMEOUT_CYCLES cycles.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters using prio
// GNT0  | requester 0 owns the transmitter until its last byte
// GNT1  | requester 1 owns the transmitter until its last byte
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   prio, prio_nxt;
    logic   last_sel;
    logic   xfer;
    logic   timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    always_comb begin
        grant      = 2'b00;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        last_sel   = 1'b0;
        unique case (state)
            GNT0: begin
                grant      = 2'b01;
                tx_valid   = req0_valid;
                tx_data    = req0_data;
                req0_ready = tx_ready;
                last_sel   = req0_last;
            end
            GNT1: begin
                grant      = 2'b10;
                tx_valid   = req1_valid;
                tx_data    = req1_data;
                req1_ready = tx_ready;
                last_sel   = req1_last;
            end
            default: ;
        endcase
    end

    assign busy = |grant;
    assign xfer = tx_valid & tx_ready;

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        unique case (state)
            IDLE: begin
                if (req0_valid && req1_valid) state_nxt = prio ? GNT1 : GNT0;
                else if (req0_valid)          state_nxt = GNT0;
                else if (req1_valid)          state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                // Both a completed packet and a forced release hand priority to the other side.
                if ((xfer && last_sel) || timeout_hit) begin
                    state_nxt = IDLE;
                    prio_nxt  = (state == GNT0);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             timeout_q;

    // Only an owner with valid low counts as stalled; UART back-pressure is not a stall.
    assign timeout_hit = busy && !tx_valid && (stall_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state == IDLE || xfer || timeout_hit) stall_cnt <= '0;
            else if (!tx_valid)                      stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000: requester-stall cycles before a forced grant release.
REQ-002 clk  input  1  system clock (100 MHz domain).
REQ-003 rst  input  1  synchronous reset, active-low.
REQ-004 req0_valid  input  1  requester 0 has a byte.
REQ-005 req0_data  input  8  requester 0 byte.
REQ-006 req0_last  input  1  byte ends requester 0 packet.
REQ-007 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-008 req1_valid / req1_data / req1_last / req1_ready: same as REQ-004..007, for requester 1.
REQ-009 tx_valid  output  1  byte offered to UART transmitter.
REQ-010 tx_data  output  8  byte to UART transmitter.
REQ-011 tx_ready  input  1  UART transmitter accepts byte.
REQ-012 grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-013 busy  output  1  grant nonzero.
REQ-014 timeout_flag  output  1  one-cycle pulse on forced release.

Function
REQ-015 FSM states: IDLE, GNT0, GNT1; grant = 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE.
REQ-016 IDLE: one requester valid -> that requester's GNT state next cycle; none valid -> stay IDLE.
REQ-017 IDLE, both valid: grant the requester selected by the round-robin pointer prio (0 or 1).
REQ-018 Grant latency: request seen in IDLE at cycle N -> grant at N+1; no transfer is possible in IDLE.
REQ-019 GNTx: tx_valid = reqx_valid, tx_data = reqx_data, reqx_ready = tx_ready (combinational); non-granted ready = 0.
REQ-020 IDLE: tx_valid = 0, tx_data = 8'h00, both readies = 0.
REQ-021 Transfer = tx_valid & tx_ready; grant is packet-locked until a transfer with reqx_last = 1.
REQ-022 Transfer with last in GNTx -> IDLE next cycle; prio set to the other requester.
REQ-023 Requester deasserting valid mid-packet does not release the grant (except per REQ-029).
REQ-024 Minimum per-packet overhead: one IDLE cycle between packets; back-to-back packets from both requesters alternate.
REQ-025 Single-byte packet (valid and last together) handled as a complete packet.

Reset
REQ-026 rst = 0 at a clock edge: state IDLE, prio = 0, timeout counter = 0, timeout_flag = 0; all outputs take their IDLE values next cycle.
REQ-027 Reset mid-packet aborts the packet with no further transfer; the requester must resend.

Configuration
REQ-028 Macro UART_TX_ARB_TIMEOUT_EN enables stall timeout.
REQ-029 Defined: counter (width $clog2(TIMEOUT_CYCLES+1)) clears on grant entry and on each transfer, and increments in GNTx when reqx_valid = 0; when the count reaches TIMEOUT_CYCLES, the FSM goes to IDLE next cycle, timeout_flag pulses for that one cycle, and prio flips to the other requester.
REQ-030 Defined: cycles with reqx_valid = 1 and tx_ready = 0 (UART back-pressure) do not increment the counter.
REQ-031 Undefined: no counter logic, timeout_flag tied 0, grant held indefinitely until last.

Verification
REQ-032 Req0 sends 3-byte packet 41,42,43 (last on 43), tx_ready = 1 -> grant = 01 one cycle after valid; tx_data 41,42,43 on consecutive cycles; IDLE the cycle after 43.
REQ-033 Both valid in IDLE after reset -> req0 granted first; at req0 last, req1 granted after one IDLE cycle; next simultaneous request -> req0 (pointer alternates).
REQ-034 Req1 granted, tx_ready held 0 for 50 cycles mid-packet -> req1_ready = 0, grant stays 10, no timeout_flag; bytes resume in order when tx_ready = 1.
REQ-035 With UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16: req0 drops valid mid-packet -> timeout_flag pulses once, 16 cycles after the stall begins; grant 00 that cycle; pending req1 granted next cycle. Without the macro: grant stays 01 for 1000 cycles and timeout_flag stays 0.
REQ-036 rst = 0 asserted during byte 2 of a req1 packet -> next cycle grant = 00, tx_valid = 0, busy = 0; after release, simultaneous requests grant req0.
